pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32: PC/offset/target width in bits.
REQ-002 Parameter RAS_DEPTH, default 4: return-address-stack entries; power of two, >=2.
REQ-003 Parameter RESET_VECTOR, default 0: PC value after reset.
REQ-004 Parameter OFFSET_SHIFT, default 2: left shift applied to branch offset (word scaling).
REQ-005 Parameter INSTR_BYTES, default 4: sequential PC increment.
REQ-006 Single clock and asynchronous active-low reset: ports clock (input, 1, rising-edge clock) and resetN (input, 1, active-low async reset) SHALL be the only clock/reset.
REQ-007 stall  input  1  hold all state this cycle.
REQ-008 branchType  input  3  0 NONE, 1 B, 2 BL, 3 CBZ, 4 CBNZ, 5 BR, 6 RET, 7 reserved.
REQ-009 zeroFlag  input  1  ALU zero result for CBZ/CBNZ.
REQ-010 pcOffsetFilled  input  WIDTH  sign-extended branch offset in instructions.
REQ-011 regTarget  input  WIDTH  register branch target (BR; RET fallback).
REQ-012 PC  output  WIDTH  current PC, registered.
REQ-013 linkAddr  output  WIDTH  last BL return address, registered.
REQ-014 rasEmpty  output  1  stack holds zero entries.
REQ-015 rasFull  output  1  stack holds RAS_DEPTH entries.
REQ-016 rasOverflow  output  1  sticky: a push occurred while full.

Function
REQ-017 State SHALL update only on rising clock edges with stall=0; with stall=1 PC, linkAddr, stack contents, count and flags SHALL hold.
REQ-018 Next PC: NONE/reserved -> PC+INSTR_BYTES; B, BL -> PC+(pcOffsetFilled<<OFFSET_SHIFT); CBZ -> taken if zeroFlag=1; CBNZ -> taken if zeroFlag=0; not-taken -> PC+INSTR_BYTES; BR -> regTarget; RET -> popped stack top, or regTarget if stack empty.
REQ-019 All additions SHALL be modulo 2^WIDTH (wrap silently); shifted offset truncated to WIDTH bits before addition.
REQ-020 Branch base SHALL be the current PC (the PC of the branching instruction), not PC+INSTR_BYTES.
REQ-021 BL SHALL push PC+INSTR_BYTES onto the stack and load linkAddr with PC+INSTR_BYTES in the same edge.
REQ-022 RET with non-empty stack SHALL pop one entry; RET with empty stack SHALL leave the stack unchanged.
REQ-023 Push when full SHALL overwrite the oldest entry (circular), keep count at RAS_DEPTH and set rasOverflow; rasOverflow clears only on reset.
REQ-024 Stack SHALL be LIFO; count range 0..RAS_DEPTH; rasEmpty/rasFull derived from registered count (no combinational path from inputs).
REQ-025 PC and linkAddr SHALL have no combinational path from any input; latency from input to PC is exactly one edge.
REQ-026 reserved type 7 SHALL behave as NONE with no stack effect.

Reset
REQ-027 On resetN low, asynchronously: PC=RESET_VECTOR, linkAddr=0, count=0, rasEmpty=1, rasFull=0, rasOverflow=0; stack entry contents need not be cleared.
REQ-028 Reset asserted mid-operation (including during stall) SHALL override everything; first update occurs on the first rising edge with resetN high.

Structure
REQ-029 Branch-type encodings (localparams/enum) SHALL reside in shared package pc_pkg, used by decoder and pc_unit.
REQ-030 Stack SHALL be a sub-module return_stack (params WIDTH, DEPTH; ports push, pop, pushData, top, empty, full, overflow) instantiated once.
REQ-031 Target 120-400 lines RTL total across both modules.

Verification
REQ-032 Reset release, 3 NONE cycles, RESET_VECTOR=0x100 -> PC 0x100, 0x104, 0x108, 0x10C.
REQ-033 PC=0x200, CBZ offset=-2, zeroFlag=1 -> PC 0x1F8; same with zeroFlag=0 -> 0x204; CBNZ mirrors.
REQ-034 PC=0x40 BL offset=4 -> PC 0x50, linkAddr 0x44; then RET -> PC 0x44, rasEmpty=1.
REQ-035 Five BLs from 0x0,0x10,0x20,0x30,0x40 (DEPTH 4) -> rasFull=1, rasOverflow=1; four RETs return 0x44,0x34,0x24,0x14; fifth RET with regTarget=0x900 -> PC 0x900.
REQ-036 stall=1 for 3 cycles with branchType=B -> PC, stack, flags unchanged; resetN pulsed low mid-stall -> PC=RESET_VECTOR immediately.
REQ-037 PC=0xFFFFFFFC NONE -> PC 0x00000000 (wrap).

Source files
------------

// File: rtl/pc_pkg.sv
// Branch-type encodings and the branch decoder shared by the PC datapath.
// The decoder turns a branch type and the zero flag into a next-PC source plus link/return intent.
package pc_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_B    = 3'd1,
    BR_BL   = 3'd2,
    BR_CBZ  = 3'd3,
    BR_CBNZ = 3'd4,
    BR_REG  = 3'd5,
    BR_RET  = 3'd6,
    BR_RSVD = 3'd7
  } br_type_e;

  typedef enum logic [1:0] {
    NEXT_SEQ = 2'd0,
    NEXT_REL = 2'd1,
    NEXT_REG = 2'd2,
    NEXT_RAS = 2'd3
  } next_sel_e;

  typedef struct packed {
    next_sel_e sel;
    logic      link;
    logic      ret;
  } br_ctrl_t;

  function automatic br_ctrl_t br_decode(input br_type_e t, input logic zero);
    br_ctrl_t c;
    c = '{sel: NEXT_SEQ, link: 1'b0, ret: 1'b0};
    case (t)
      BR_B:    c.sel = NEXT_REL;
      BR_BL:   begin c.sel = NEXT_REL; c.link = 1'b1; end
      BR_CBZ:  c.sel = zero ? NEXT_REL : NEXT_SEQ;
      BR_CBNZ: c.sel = zero ? NEXT_SEQ : NEXT_REL;
      BR_REG:  c.sel = NEXT_REG;
      BR_RET:  begin c.sel = NEXT_RAS; c.ret = 1'b1; end
      default: c.sel = NEXT_SEQ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack; a push while full overwrites the oldest entry and sets a sticky overflow.
// Flags come straight from registered count; top is a read of the registered array.
module return_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] pushData,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rd_ptr;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  // wptr always names the next free slot; when full that slot holds the oldest entry
  assign rd_ptr   = wptr_q - PTR_W'(1);
  assign top      = mem_q[rd_ptr];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign overflow = ovf_q;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push) begin
      mem_d[wptr_q] = pushData;
      wptr_d        = wptr_q + PTR_W'(1);
      if (full) ovf_d = 1'b1;
      else      count_d = count_q + CNT_W'(1);
    end else if (pop && !empty) begin
      wptr_d  = rd_ptr;
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with relative/conditional/register branches and a return-address stack.
// PC and linkAddr are registered; stall freezes every piece of state for the cycle.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               RAS_DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               OFFSET_SHIFT = 2,
  parameter int               INSTR_BYTES  = 4
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             stall,
  input  logic [2:0]       branchType,
  input  logic             zeroFlag,
  input  logic [WIDTH-1:0] pcOffsetFilled,
  input  logic [WIDTH-1:0] regTarget,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] linkAddr,
  output logic             rasEmpty,
  output logic             rasFull,
  output logic             rasOverflow
);

  localparam logic [WIDTH-1:0] INC = WIDTH'(INSTR_BYTES);

  logic [WIDTH-1:0] pc_q, pc_d, link_q, link_d;
  logic [WIDTH-1:0] seq_pc, rel_pc, ras_top;
  logic             ras_push, ras_pop;
  br_ctrl_t         ctrl;

  assign ctrl = br_decode(br_type_e'(branchType), zeroFlag);

  always_comb begin
    seq_pc   = pc_q + INC;
    // shift is evaluated at WIDTH bits, so offset bits shifted past the top are dropped
    rel_pc   = pc_q + (pcOffsetFilled << OFFSET_SHIFT);
    pc_d     = pc_q;
    link_d   = link_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (!stall) begin
      case (ctrl.sel)
        NEXT_REL: pc_d = rel_pc;
        NEXT_REG: pc_d = regTarget;
        NEXT_RAS: pc_d = rasEmpty ? regTarget : ras_top;
        default:  pc_d = seq_pc;
      endcase
      if (ctrl.link) begin
        link_d   = seq_pc;
        ras_push = 1'b1;
      end
      ras_pop = ctrl.ret && !rasEmpty;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      pc_q   <= RESET_VECTOR;
      link_q <= '0;
    end else begin
      pc_q   <= pc_d;
      link_q <= link_d;
    end
  end

  return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock    (clock),
    .resetN   (resetN),
    .push     (ras_push),
    .pop      (ras_pop),
    .pushData (seq_pc),
    .top      (ras_top),
    .empty    (rasEmpty),
    .full     (rasFull),
    .overflow (rasOverflow)
  );

  assign PC       = pc_q;
  assign linkAddr = link_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed and random stimulus for pc_unit against a queue-based reference model.
module tb_pc_unit;

  localparam int          D  = 4;
  localparam logic [31:0] RV = 32'h100;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  branchType = 3'd0;
  logic        zeroFlag = 1'b0;
  logic [31:0] pcOffsetFilled = '0;
  logic [31:0] regTarget = '0;
  logic [31:0] PC, linkAddr;
  logic        rasEmpty, rasFull, rasOverflow;

  pc_unit #(
    .WIDTH(32), .RAS_DEPTH(D), .RESET_VECTOR(RV), .OFFSET_SHIFT(2), .INSTR_BYTES(4)
  ) dut (
    .clock(clock), .resetN(resetN), .stall(stall), .branchType(branchType),
    .zeroFlag(zeroFlag), .pcOffsetFilled(pcOffsetFilled), .regTarget(regTarget),
    .PC(PC), .linkAddr(linkAddr), .rasEmpty(rasEmpty), .rasFull(rasFull),
    .rasOverflow(rasOverflow)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc, m_link;
  logic        m_ovf;
  logic [31:0] m_stk[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"}, PC, m_pc);
    chk({tag, ".link"}, linkAddr, m_link);
    chk({tag, ".empty"}, {31'b0, rasEmpty}, {31'b0, m_stk.size() == 0});
    chk({tag, ".full"}, {31'b0, rasFull}, {31'b0, m_stk.size() == D});
    chk({tag, ".ovf"}, {31'b0, rasOverflow}, {31'b0, m_ovf});
  endtask

  task automatic model_reset();
    m_pc   = RV;
    m_link = '0;
    m_ovf  = 1'b0;
    m_stk.delete();
  endtask

  // Applies one clock edge worth of architectural behaviour using the current inputs.
  task automatic model_step();
    logic [31:0] seq, tgt;
    if (stall) return;
    seq = m_pc + 32'd4;
    tgt = m_pc + (pcOffsetFilled * 32'd4);
    case (branchType)
      3'd1: m_pc = tgt;
      3'd2: begin
        if (m_stk.size() == D) begin
          void'(m_stk.pop_front());
          m_ovf = 1'b1;
        end
        m_stk.push_back(seq);
        m_link = seq;
        m_pc   = tgt;
      end
      3'd3: m_pc = zeroFlag ? tgt : seq;
      3'd4: m_pc = zeroFlag ? seq : tgt;
      3'd5: m_pc = regTarget;
      3'd6: m_pc = (m_stk.size() > 0) ? m_stk.pop_back() : regTarget;
      default: m_pc = seq;
    endcase
  endtask

  task automatic step(input logic [2:0] bt, input logic [31:0] off, input logic [31:0] rt,
                      input logic z, input logic st, input string tag);
    branchType     = bt;
    pcOffsetFilled = off;
    regTarget      = rt;
    zeroFlag       = z;
    stall          = st;
    @(posedge clock);
    model_step();
    #1;
    chk_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    chk_all("reset");
    resetN = 1'b1;

    // sequential fetch from the reset vector
    step(3'd0, 0, 0, 0, 0, "seq1");
    step(3'd0, 0, 0, 0, 0, "seq2");
    step(3'd0, 0, 0, 0, 0, "seq3");
    chk("seq_const", PC, 32'h10C);

    // conditional branches from 0x200 with offset -2
    step(3'd5, 0, 32'h200, 0, 0, "go200a");
    step(3'd3, 32'hFFFF_FFFE, 0, 1, 0, "cbz_t");
    chk("cbz_t_const", PC, 32'h1F8);
    step(3'd5, 0, 32'h200, 0, 0, "go200b");
    step(3'd3, 32'hFFFF_FFFE, 0, 0, 0, "cbz_nt");
    chk("cbz_nt_const", PC, 32'h204);
    step(3'd5, 0, 32'h200, 0, 0, "go200c");
    step(3'd4, 32'hFFFF_FFFE, 0, 0, 0, "cbnz_t");
    chk("cbnz_t_const", PC, 32'h1F8);
    step(3'd5, 0, 32'h200, 0, 0, "go200d");
    step(3'd4, 32'hFFFF_FFFE, 0, 1, 0, "cbnz_nt");
    chk("cbnz_nt_const", PC, 32'h204);

    // call and return
    step(3'd5, 0, 32'h40, 0, 0, "go40");
    step(3'd2, 32'd4, 0, 0, 0, "bl");
    chk("bl_pc_const", PC, 32'h50);
    chk("bl_link_const", linkAddr, 32'h44);
    step(3'd6, 0, 32'hDEAD_0000, 0, 0, "ret");
    chk("ret_pc_const", PC, 32'h44);
    chk("ret_empty_const", {31'b0, rasEmpty}, 32'd1);

    // stack overflow and unwinding
    step(3'd5, 0, 32'h0, 0, 0, "go0");
    for (int i = 0; i < 5; i++) step(3'd2, 32'd4, 0, 0, 0, "bl_chain");
    chk("ovf_full_const", {31'b0, rasFull}, 32'd1);
    chk("ovf_flag_const", {31'b0, rasOverflow}, 32'd1);
    step(3'd6, 0, 32'h900, 0, 0, "ret1");
    chk("ret1_const", PC, 32'h44);
    step(3'd6, 0, 32'h900, 0, 0, "ret2");
    chk("ret2_const", PC, 32'h34);
    step(3'd6, 0, 32'h900, 0, 0, "ret3");
    chk("ret3_const", PC, 32'h24);
    step(3'd6, 0, 32'h900, 0, 0, "ret4");
    chk("ret4_const", PC, 32'h14);
    step(3'd6, 0, 32'h900, 0, 0, "ret5");
    chk("ret5_const", PC, 32'h900);

    // stall holds everything, reset mid-stall wins immediately
    step(3'd2, 32'd8, 0, 0, 0, "pre_stall_bl");
    for (int i = 0; i < 3; i++) step(3'd1, 32'd16, 0, 0, 1, "stall_b");
    chk("stall_pc_const", PC, 32'h920);
    #2;
    resetN = 1'b0;
    #1;
    model_reset();
    chk_all("reset_mid_stall");
    @(negedge clock);
    resetN = 1'b1;
    stall  = 1'b0;
    step(3'd0, 0, 0, 0, 0, "post_reset");
    chk("post_reset_const", PC, RV + 32'd4);

    // wrap at the top of the address space
    step(3'd5, 0, 32'hFFFF_FFFC, 0, 0, "go_top");
    step(3'd0, 0, 0, 0, 0, "wrap");
    chk("wrap_const", PC, 32'h0);

    // random mix of all branch types, including stalls and the reserved encoding
    for (int i = 0; i < 400; i++) begin
      logic [31:0] off;
      off = 32'($urandom_range(0, 63)) - 32'd32;
      if ($urandom_range(0, 9) == 0) off = $urandom;
      step(3'($urandom_range(0, 7)), off, $urandom, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
